// File: rtl/pump_pwm_gen.sv
// Two-channel PWM generator for the pump drives: shared prescaler and 8-bit period
// counter, per-channel duty shadowing at period wrap with an optional slew limiter.
module pump_pwm_gen #(
  parameter int PRESCALE  = 195,
  parameter bit SLEW_EN   = 1'b1,
  parameter int SLEW_STEP = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] pwm_duty_a,
  input  logic [7:0] pwm_duty_b,
  output logic       pwm_out_a,
  output logic       pwm_out_b,
  output logic [7:0] duty_applied_a,
  output logic [7:0] duty_applied_b,
  output logic       period_tick
);

  localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE);
  localparam logic [8:0]    STEP9     = 9'(SLEW_STEP);
  localparam logic [7:0]    STEP8     = 8'(SLEW_STEP);

  logic [PW-1:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic [7:0]    applied_a_q, applied_a_d;
  logic [7:0]    applied_b_q, applied_b_d;
  logic          period_tick_q, period_tick_d;
  logic          pwm_out_a_q, pwm_out_a_d;
  logic          pwm_out_b_q, pwm_out_b_d;
  logic          tick;
  logic          wrap;

  // Move the applied duty toward the command; the upward sum is kept in 9 bits so
  // a large step near 255 clamps to the command instead of wrapping.
  function automatic logic [7:0] next_duty(input logic [7:0] cur, input logic [7:0] cmd);
    logic [8:0] up;
    logic [7:0] gap;
    up        = {1'b0, cur} + STEP9;
    gap       = cur - cmd;
    next_duty = cur;
    if (!SLEW_EN) begin
      next_duty = cmd;
    end else if (cmd > cur) begin
      next_duty = (up > {1'b0, cmd}) ? cmd : up[7:0];
    end else if (cmd < cur) begin
      next_duty = (gap > STEP8) ? (cur - STEP8) : cmd;
    end
  endfunction

  always_comb begin
    tick          = (presc_cnt_q == PRESC_MAX);
    wrap          = tick && (pwm_cnt_q == 8'hFF);
    presc_cnt_d   = tick ? '0 : presc_cnt_q + PW'(1);
    pwm_cnt_d     = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    applied_a_d   = wrap ? next_duty(applied_a_q, pwm_duty_a) : applied_a_q;
    applied_b_d   = wrap ? next_duty(applied_b_q, pwm_duty_b) : applied_b_q;
    period_tick_d = wrap;
    pwm_out_a_d   = (pwm_cnt_q < applied_a_q);
    pwm_out_b_d   = (pwm_cnt_q < applied_b_q);
    // Disable abandons the current period and clears the ramp so it restarts from 0.
    if (!enable) begin
      presc_cnt_d   = '0;
      pwm_cnt_d     = '0;
      applied_a_d   = '0;
      applied_b_d   = '0;
      period_tick_d = 1'b0;
      pwm_out_a_d   = 1'b0;
      pwm_out_b_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_cnt_q   <= '0;
      pwm_cnt_q     <= '0;
      applied_a_q   <= '0;
      applied_b_q   <= '0;
      period_tick_q <= 1'b0;
      pwm_out_a_q   <= 1'b0;
      pwm_out_b_q   <= 1'b0;
    end else begin
      presc_cnt_q   <= presc_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      applied_a_q   <= applied_a_d;
      applied_b_q   <= applied_b_d;
      period_tick_q <= period_tick_d;
      pwm_out_a_q   <= pwm_out_a_d;
      pwm_out_b_q   <= pwm_out_b_d;
    end
  end

  assign pwm_out_a      = pwm_out_a_q;
  assign pwm_out_b      = pwm_out_b_q;
  assign duty_applied_a = applied_a_q;
  assign duty_applied_b = applied_b_q;
  assign period_tick    = period_tick_q;

endmodule
